// File: rtl/gamate_video_post.sv
// gamate_video_post: shade->RGB post-processor (palette, prev-frame blend, drop shadow); in: clk reset ce_pix pixel syncs ctrl pal_wr/addr/data; out: r g b + 2-ce delayed syncs
module gamate_video_post #(
  parameter int H_ACTIVE = 160,
  parameter int V_ACTIVE = 150,
  parameter int FB_AW = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic [1:0] pixel,
  input  logic       hblank,
  input  logic       vblank,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       blend_en,
  input  logic       shadow_en,
  input  logic       pal_sel,
  input  logic       pal_wr,
  input  logic [3:0] pal_addr,
  input  logic [7:0] pal_data,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       hblank_out,
  output logic       vblank_out,
  output logic       hsync_out,
  output logic       vsync_out
);
  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int LW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [FB_AW-1:0] FB_END = FB_AW'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [11:0][7:0] DEF_PAL = {8'h49, 8'h3B, 8'h1A, 8'h5F, 8'h5A, 8'h30,
                                          8'h56, 8'h73, 8'h51, 8'h14, 8'h82, 8'h82};
  logic [1:0] fb_mem [0:H_ACTIVE*V_ACTIVE-1];
  logic [1:0] lb_mem [0:H_ACTIVE-1];
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [FB_AW-1:0] fb_addr_q, fb_addr_d;
  logic fb_full_q, fb_full_d, fb_valid_q, fb_valid_d, sc_ok_q, sc_ok_d, active;
  logic [1:0] pix_q, pix_d, prev_q, above_q, sc_q, sc;
  logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0][7:0] rgb_q, rgb_d;
  logic [11:0][7:0] pal_q, pal_d, pal_cur;

  function automatic logic [7:0] colour(input logic [11:0][7:0] pal, input logic [1:0] p,
                                        input logic [1:0] pv, input logic [1:0] s,
                                        input logic blend, input logic [1:0] i);
    logic [8:0] sum;
    logic [7:0] c;
    sum = {1'b0, pal[{2'b0, p} * 4'd3 + {2'b0, i}]} + {1'b0, pal[{2'b0, pv} * 4'd3 + {2'b0, i}]};
    c = blend ? sum[8:1] : pal[{2'b0, p} * 4'd3 + {2'b0, i}];
    return (p == 2'd0 && s != 2'd0) ?
           (c >> 1) + (c >> 2) + (s[1] ? 8'd0 : c >> 3) + (s[0] ? 8'd0 : c >> 4) : c;
  endfunction

  always_comb begin
    active = !hblank && !vblank;
    sc = (shadow_en && sc_ok_q) ? sc_q : 2'd0;
    pal_cur = pal_sel ? pal_q : DEF_PAL;
    pal_d = pal_q;
    if (pal_wr && pal_addr < 4'd12) pal_d[pal_addr] = pal_data;
    x_d = !ce_pix ? x_q : hblank ? '0 : active ? x_q + XW'(1) : x_q;
    y_d = !ce_pix ? y_q : vblank ? '0 : (hblank && sync1_q[3:2] == 2'b00) ? y_q + YW'(1) : y_q;
    fb_addr_d = !ce_pix ? fb_addr_q : vsync ? '0 :
                (active && fb_addr_q != FB_END) ? fb_addr_q + FB_AW'(1) : fb_addr_q;
    fb_full_d = !ce_pix ? fb_full_q : vsync ? 1'b0 : fb_full_q | (active && fb_addr_q == FB_END);
    fb_valid_d = fb_valid_q | (ce_pix & vsync & fb_full_q);
    pix_d = ce_pix ? pixel : pix_q;
    sync1_d = ce_pix ? {hblank, vblank, hsync, vsync} : sync1_q;
    sc_ok_d = ce_pix ? (x_q != '0 && y_q != '0) : sc_ok_q;
    sync2_d = ce_pix ? sync1_q : sync2_q;
    for (int i = 0; i < 3; i++)
      rgb_d[i] = !ce_pix ? rgb_q[i] : (sync1_q[3] | sync1_q[2]) ? 8'd0 :
                 colour(pal_cur, pix_q, prev_q, sc, blend_en & fb_valid_q, 2'(i));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
      fb_addr_q <= '0;
      fb_full_q <= 1'b0;
      fb_valid_q <= 1'b0;
      pix_q <= 2'd0;
      sc_ok_q <= 1'b0;
      sync1_q <= 4'b1100;
      sync2_q <= 4'b1100;
      rgb_q <= '0;
      pal_q <= DEF_PAL;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      fb_addr_q <= fb_addr_d;
      fb_full_q <= fb_full_d;
      fb_valid_q <= fb_valid_d;
      pix_q <= pix_d;
      sc_ok_q <= sc_ok_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      rgb_q <= rgb_d;
      pal_q <= pal_d;
    end
  end

  // above_q holds the previous line's pixel at x; delaying it one more pixel yields above-left
  always_ff @(posedge clk) begin
    if (ce_pix) begin
      prev_q <= fb_mem[fb_addr_q];
      above_q <= lb_mem[x_q[LW-1:0]];
      sc_q <= above_q;
      if (active) begin
        fb_mem[fb_addr_q] <= pixel;
        lb_mem[x_q[LW-1:0]] <= pixel;
      end
    end
  end

  assign r = rgb_q[0];
  assign g = rgb_q[1];
  assign b = rgb_q[2];
  assign {hblank_out, vblank_out, hsync_out, vsync_out} = sync2_q;
endmodule

// File: doc/gamate_video_post.md
Name: gamate_video_post

Overview:
Pixel post-processor between the gamate core video outputs and the video_mixer. It takes the 2-bit LCD shade stream with its blank/sync strobes and applies palette lookup, optional previous-frame flicker blend and optional diagonal drop shadow. It outputs 8-bit RGB with syncs delayed to match. It owns the previous-frame buffer, the previous-line buffer and the default/user palette registers; the user palette is loaded from the HPS download path.

Parameters:
H_ACTIVE, 160, active pixels per line
V_ACTIVE, 150, active lines per frame
FB_AW, 15, frame buffer address width (must hold H_ACTIVE*V_ACTIVE)

Ports:
clk  in  1  system clock (clk_sys)
reset  in  1  synchronous, active-high
ce_pix  in  1  pixel enable; all video pipeline stages advance only when high
pixel  in  2  shade index, 0 = lightest
hblank  in  1  horizontal blank
vblank  in  1  vertical blank
hsync  in  1  horizontal sync
vsync  in  1  vertical sync
blend_en  in  1  1 = average with previous frame
shadow_en  in  1  1 = drop shadow on
pal_sel  in  1  1 = user palette, 0 = default palette
pal_wr  in  1  palette byte write strobe, independent of ce_pix
pal_addr  in  4  palette byte address
pal_data  in  8  palette byte
r  out  8  red
g  out  8  green
b  out  8  blue
hblank_out  out  1  delayed hblank
vblank_out  out  1  delayed vblank
hsync_out  out  1  delayed hsync
vsync_out  out  1  delayed vsync

Behaviour:
- Reset values:
  - r/g/b = 0; hblank_out = vblank_out = 1; hsync_out = vsync_out = 0.
  - x/y/fb_addr counters = 0; fb_valid = 0.
  - User palette = default: entry0 828214, entry1 517356, entry2 305A5F, entry3 1A3B49.
  - Frame and line buffer contents are not cleared.
- Latency: exactly 2 ce_pix from input sample to r/g/b. All four sync/blank outputs are delayed by the same 2 ce_pix. Outputs hold between ce_pix pulses.
- Stage 1 (ce_pix):
  - Register pixel and syncs.
  - Frame buffer: read at fb_addr and write pixel at fb_addr in the same cycle. Read-during-write returns old data, i.e. the previous frame's value.
  - Line buffer: read above-left at x-1; write at x.
- Counters:
  - x increments on active ce_pix and clears while hblank.
  - y increments at each active-line end and clears while vblank.
  - fb_addr increments on active ce_pix and clears on ce_pix while vsync. It saturates at H_ACTIVE*V_ACTIVE-1 and never wraps.
- Shadow source:
  - sc = pixel at (x-1, y-1).
  - sc is forced to 0 when x == 0, y == 0, or shadow_en == 0.
- Stage 2, colour per component:
  - c = pal[p].
  - If blend_en and fb_valid: c = (pal[p] + pal[prev]) >> 1, using a 9-bit sum truncated to 8 bits.
  - If p == 0 and sc != 0: c = (c>>1) + (c>>2) + (sc[1]?0:c>>3) + (sc[0]?0:c>>4). This gives 0.75 / 0.8125 / 0.875 for sc = 3 / 2 / 1.
  - If the stage-1 blank (hblank|vblank) is set, r/g/b = 0.
- fb_valid: set on the first vsync ce_pix after fb_addr reaches its final active address. It stays 1 until reset. While 0, blend is bypassed.
- Palette write:
  - pal_addr 0..11 selects entry = addr/3; component addr%3 gives 0 = R, 1 = G, 2 = B.
  - Addresses 12..15 are ignored.
  - A write takes effect on the next clk, even mid-line. The default palette is constant.
- pal_sel, blend_en and shadow_en are sampled at stage 2. Toggling mid-frame takes effect on the next ce_pix.
- Reset mid-frame: counters restart. The first post-reset frame is unblended.
- Simultaneous pal_wr and ce_pix: both act. The pixel uses the pre-write palette value if the read and write fall in the same cycle.

Test Plan:
- Reset, then frame of all pixel=1, blend off, shadow off, pal_sel=0 -> active r/g/b = 51/73/56 after exactly 2 ce_pix; blanked positions 0/0/0; sync outputs equal inputs delayed 2 ce_pix.
- Frame A all 0, then frame B all 3, blend on -> frame A output 82/82/14 (fb_valid=0); frame B output (82+1A)>>1 = 4E, 4E, (14+49)>>1 = 2E.
- Single pixel=3 at (10,10), rest 0, shadow on, blend off -> (11,11) outputs 82*0.75 = 61, 61, 0F; (0,y) and line 0 never shadowed; shadow off -> 82/82/14.
- pal_wr addr 3..5 = FF,00,80, pal_sel=1, pixel=1 -> FF/00/80; addr 13 write -> no change; pal_sel=0 -> 51/73/56.
- Assert reset mid-line of frame 2 with blend on -> outputs reset values next clk; following frame unblended; fb_addr restarts at 0 on the next vsync.
- Overlong frame of 160x152 active pixels -> fb_addr holds at 23999 and no write goes beyond it; next frame blends correctly.
